// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: Funct3 encodings, FSM states
// and the byte-lane helpers used by the top level.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, LD_HI, LD_LAST, ST_HI} lsu_state_t;

  function automatic logic load_legal(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic store_legal(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
  endfunction

  // Lanes touched across two consecutive words: [3:0] first word, [7:4] spill.
  function automatic logic [7:0] lane_mask(input logic [1:0] sz, input logic [1:0] o);
    logic [7:0] base;
    case (sz)
      2'b00:   base = 8'h01;
      2'b01:   base = 8'h03;
      default: base = 8'h0F;
    endcase
    return base << o;
  endfunction

endpackage

// File: rtl/lsu_load_fmt.sv
// Load formatter: aligns the byte lanes of a (possibly two-word) read and
// applies sign or zero extension according to Funct3.
module lsu_load_fmt
  import lsu_pkg::*;
(
  input  logic [31:0] lo,
  input  logic [31:0] hi,
  input  logic [1:0]  o,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [63:0] pair;
  logic [31:0] sh;

  assign pair = {hi, lo};
  assign sh   = 32'(pair >> {o, 3'b000});

  always_comb begin
    result = sh;
    case (funct3)
      F3_B:    result = {{24{sh[7]}}, sh[7:0]};
      F3_H:    result = {{16{sh[15]}}, sh[15:0]};
      F3_BU:   result = {24'd0, sh[7:0]};
      F3_HU:   result = {16'd0, sh[15:0]};
      default: result = sh;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: byte-lane stores, extended loads, and
// two-cycle splitting of accesses that straddle a word boundary.
//
// state   | meaning
// IDLE    | accept a request; first (or only) word access
// LD_HI   | low word captured from mem_rd; reading word w+1
// LD_LAST | formatted load result on rdata
// ST_HI   | writing the spill lanes of a split store to word w+1
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DM_ADDRESS = 9,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            Funct3,
  input  logic [DM_ADDRESS-1:0] addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic                  stall,
  output logic [DATA_W-1:0]     rdata,
  output logic                  rdata_valid,
  output logic                  err,
  output logic [DM_ADDRESS-1:0] mem_addr,
  output logic [3:0]            mem_wr,
  output logic [DATA_W-1:0]     mem_wd,
  input  logic [DATA_W-1:0]     mem_rd
);

  localparam int WW = DM_ADDRESS - 2;

  lsu_state_t state, state_nxt;

  logic [2:0]            f3_q;
  logic [DM_ADDRESS-1:0] addr_q;
  logic [DATA_W-1:0]     wdata_q;
  logic [DATA_W-1:0]     lo_q;

  logic                  ld_ok, st_ok, accept;
  logic [7:0]            mask_in, mask_q;
  logic [DATA_W-1:0]     wsh_in;
  logic [2*DATA_W-1:0]   wsh_q;
  logic [WW-1:0]         w_inc;
  logic                  split_q;
  logic [DATA_W-1:0]     fmt_lo, fmt_hi, fmt_out;

  // A load wins when both strobes are high.
  assign ld_ok  = MemRead && load_legal(Funct3);
  assign st_ok  = !MemRead && MemWrite && store_legal(Funct3);
  assign accept = (state == IDLE) && (ld_ok || st_ok);

  assign mask_in = lane_mask(Funct3[1:0], addr[1:0]);
  assign mask_q  = lane_mask(f3_q[1:0], addr_q[1:0]);
  assign wsh_in  = wdata << {addr[1:0], 3'b000};
  assign wsh_q   = {{DATA_W{1'b0}}, wdata_q} << {addr_q[1:0], 3'b000};
  assign w_inc   = addr_q[DM_ADDRESS-1:2] + WW'(1);
  assign split_q = |mask_q[7:4];

  // Aligned loads take their only word straight from mem_rd.
  assign fmt_lo = split_q ? lo_q : mem_rd;
  assign fmt_hi = split_q ? mem_rd : '0;

  lsu_load_fmt u_fmt (
    .lo     (fmt_lo),
    .hi     (fmt_hi),
    .o      (addr_q[1:0]),
    .funct3 (f3_q),
    .result (fmt_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        f3_q    <= Funct3;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      if (state == LD_HI) lo_q <= mem_rd;
    end
  end

  always_comb begin
    state_nxt   = state;
    stall       = 1'b0;
    rdata       = '0;
    rdata_valid = 1'b0;
    err         = 1'b0;
    mem_addr    = '0;
    mem_wr      = '0;
    mem_wd      = '0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (MemRead) begin
            if (ld_ok) begin
              mem_addr  = {addr[DM_ADDRESS-1:2], 2'b00};
              stall     = 1'b1;
              state_nxt = (|mask_in[7:4]) ? LD_HI : LD_LAST;
            end else begin
              err         = 1'b1;
              rdata_valid = 1'b1;
            end
          end else if (MemWrite) begin
            if (st_ok) begin
              mem_addr = {addr[DM_ADDRESS-1:2], 2'b00};
              mem_wr   = mask_in[3:0];
              mem_wd   = wsh_in;
              if (|mask_in[7:4]) begin
                stall     = 1'b1;
                state_nxt = ST_HI;
              end
            end else begin
              err = 1'b1;
            end
          end
        end
        LD_HI: begin
          mem_addr  = {w_inc, 2'b00};
          stall     = 1'b1;
          state_nxt = LD_LAST;
        end
        LD_LAST: begin
          rdata_valid = 1'b1;
          rdata       = fmt_out;
          state_nxt   = IDLE;
        end
        ST_HI: begin
          mem_addr  = {w_inc, 2'b00};
          mem_wr    = mask_q[7:4];
          mem_wd    = wsh_q[2*DATA_W-1:DATA_W];
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory-stage load/store unit between the EX/MEM pipeline register and the data memory.
- Stores: turns a RISC-V load/store request (byte address, Funct3, store data) into word-aligned memory accesses with per-byte write enables.
- Loads: extracts and sign/zero-extends the loaded value.
- Misaligned accesses: split into two word accesses, with the pipeline stalled for the extra cycle.

## Interface
Parameters:
- DM_ADDRESS, 9, byte-address width of the data memory
- DATA_W, 32, data width; block supports 32 only

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- MemRead  in  1  load request from control unit
- MemWrite  in  1  store request from control unit
- Funct3  in  3  instruction bits 14:12
- addr  in  DM_ADDRESS  byte address (ALU result LSBs)
- wdata  in  DATA_W  store data (rs2)
- stall  out  1  pipeline must hold EX/MEM inputs stable this cycle
- rdata  out  DATA_W  extended load result
- rdata_valid  out  1  rdata valid this cycle
- err  out  1  one-cycle pulse: illegal Funct3
- mem_addr  out  DM_ADDRESS  word-aligned byte address, bits [1:0] = 0
- mem_wr  out  4  byte write enables, bit i = byte lane i
- mem_wd  out  DATA_W  lane-aligned write data
- mem_rd  in  DATA_W  memory read data, valid one cycle after mem_addr

## Operation
- Decode: o = addr[1:0]; w = addr[DM_ADDRESS-1:2]; w+1 wraps modulo 2^(DM_ADDRESS-2).
- Legal load Funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- Legal store Funct3: 000 SB, 001 SH, 010 SW.
- Illegal Funct3 (any other value): no memory access, mem_wr=0, rdata=0; err and rdata_valid pulse for one cycle (stores: err only).
- MemRead and MemWrite both high: load performed, store ignored.
- Size n = 1/2/4 bytes. Access is split when o+n > 4.
- Store lane enables:
  - first access: ((1<<n)-1) << o, truncated to 4 bits; mem_wd = wdata << 8*o.
  - second access (split only): (1<<(o+n-4))-1 at word w+1; mem_wd = wdata >> 8*(4-o).
- Load: the byte lanes are concatenated, low word first, then shifted right by 8*o.
  - LB/LH: sign-extend from bit 7/15.
  - LBU/LHU: zero-extend.
- FSM states: IDLE, LD_HI, LD_LAST, ST_HI.
  - IDLE + load: drive word w. Next state LD_HI if split, else LD_LAST.
  - LD_HI: register mem_rd as the low word; drive word w+1. Next state LD_LAST.
  - LD_LAST: format rdata; rdata_valid=1. Next state IDLE.
  - IDLE + split store: write first part. Next state ST_HI.
  - IDLE + aligned store: write, stay IDLE.
  - ST_HI: write second part. Next state IDLE.
- The request (Funct3, addr, wdata) is registered on acceptance in IDLE; later states use the registered copy.
- stall = 1 in IDLE when accepting a load or a split store, and in LD_HI; 0 otherwise.

## Timing
- Reset: state IDLE, registered low word = 0.
- Reset values of outputs: stall=0, rdata=0, rdata_valid=0, err=0, mem_wr=0, mem_wd=0, mem_addr=0.
- Reset mid-operation: the pending access is dropped with no further writes, and nothing is returned.
- Latency, counting cycle A as acceptance:
  - aligned load: result in A+1.
  - split load: result in A+2.
  - aligned store: written in A, no stall.
  - split store: written in A and A+1.
- stall is low in the final cycle of every operation, so back-to-back requests issue with no bubble.
- mem_wr is nonzero only in the store write cycles; it is 0 in every load cycle.
- rdata_valid and err are single-cycle pulses.
- rdata holds 0 when rdata_valid=0.

## Structure
- Package lsu_pkg: Funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU) and the FSM state enum lsu_state_t.
- Sub-module lsu_load_fmt: combinational block. Inputs: low word, high word, o, Funct3. Output: extended 32-bit result. Shared by the aligned and split load paths.

## Test plan
- SW 0xDEADBEEF at addr 0x010 → mem_wr=1111, mem_addr=0x010, mem_wd=0xDEADBEEF, stall=0. Then LW 0x010 → rdata=0xDEADBEEF at A+1, stall high at A only.
- SB 0x000000A5 at 0x013 → mem_wr=1000, mem_wd=0xA5000000. Then LB 0x013 → 0xFFFFFFA5; LBU 0x013 → 0x000000A5.
- SW 0x11223344 at 0x006 (split):
  - A: mem_addr 0x004, mem_wr=1100, mem_wd=0x33440000.
  - A+1: mem_addr 0x008, mem_wr=0011, mem_wd=0x00001122.
  - Then LW 0x006 → 0x11223344 at A+2, stall high at A and A+1.
- LH at 0x1FF with DM_ADDRESS=9 → second word access wraps to mem_addr 0x000; result is sign-extended.
- Funct3=011 with MemRead → no access, err=1 and rdata_valid=1 with rdata=0 for one cycle. MemRead and MemWrite both high → mem_wr stays 0.
- Reset asserted in LD_HI of a split load → next cycle: IDLE, rdata_valid=0, stall=0, no write issued.
